// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: steps each latched instruction through fetch/decode/execute/memory/writeback
// and drives the active-low data-memory strobes, holding access states for MEM_WAIT extra cycles.
module mips_mc_ctrl #(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [3:0] state,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_src,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       CEN,
  output logic       WEN,
  output logic       OEN,
  output logic       illegal
);

  localparam logic [3:0] S_RST     = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_EXEC_R  = 4'd3;
  localparam logic [3:0] S_EXEC_SH = 4'd4;
  localparam logic [3:0] S_WB_R    = 4'd5;
  localparam logic [3:0] S_EXEC_I  = 4'd6;
  localparam logic [3:0] S_WB_I    = 4'd7;
  localparam logic [3:0] S_MADDR   = 4'd8;
  localparam logic [3:0] S_MRD     = 4'd9;
  localparam logic [3:0] S_WB_M    = 4'd10;
  localparam logic [3:0] S_MWR     = 4'd11;
  localparam logic [3:0] S_BRANCH  = 4'd12;
  localparam logic [3:0] S_JUMP    = 4'd13;
  localparam logic [3:0] S_JR      = 4'd14;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  logic [3:0] next_state;
  logic [3:0] wait_cnt;
  logic       link;
  logic       mem_state;
  logic       mem_done;

  assign mem_state = (state == S_MRD) || (state == S_MWR);
  assign mem_done  = (wait_cnt == WAIT_LAST);

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_RST:    next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          6'h00: begin
            case (funct)
              6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: next_state = S_EXEC_R;
              6'h00, 6'h02:                      next_state = S_EXEC_SH;
              6'h08:                             next_state = S_JR;
              default:                           next_state = S_FETCH;
            endcase
          end
          6'h08:        next_state = S_EXEC_I;
          6'h23, 6'h2B: next_state = S_MADDR;
          6'h04, 6'h05: next_state = S_BRANCH;
          6'h02, 6'h03: next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_SH: next_state = S_WB_R;
      S_EXEC_I: next_state = S_WB_I;
      S_MADDR:  next_state = (op == 6'h23) ? S_MRD : ((op == 6'h2B) ? S_MWR : S_FETCH);
      S_MRD:    next_state = mem_done ? S_WB_M : S_MRD;
      S_MWR:    next_state = mem_done ? S_FETCH : S_MWR;
      default:  next_state = S_FETCH;
    endcase
  end

  // An unsupported instruction is exactly a decode that falls straight back to fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RST;
      wait_cnt <= 4'd0;
      illegal  <= 1'b0;
      link     <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= (mem_state && next_state == state) ? wait_cnt + 4'd1 : 4'd0;
      if (state == S_DECODE) begin
        link <= (op == 6'h03);
        if (next_state == S_FETCH)
          illegal <= 1'b1;
      end
    end
  end

  // Moore decode; the branch-taken decision is the only input-dependent output.
  always_comb begin
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    reg_dst   = 2'd0;
    wb_src    = 2'd0;
    alu_src_b = 2'd0;
    alu_op    = 2'd0;
    case (state)
      S_FETCH:   begin ir_write = 1'b1; pc_write = 1'b1; end
      S_DECODE:  alu_src_b = 2'd3;
      S_EXEC_R:  alu_op = 2'd2;
      S_EXEC_SH: begin alu_src_b = 2'd2; alu_op = 2'd2; end
      S_WB_R:    begin reg_write = 1'b1; reg_dst = 2'd1; end
      S_EXEC_I:  alu_src_b = 2'd1;
      S_WB_I:    reg_write = 1'b1;
      S_MADDR:   alu_src_b = 2'd1;
      S_WB_M:    begin reg_write = 1'b1; wb_src = 2'd1; end
      S_BRANCH:  begin
        alu_op   = 2'd1;
        pc_src   = 2'd1;
        pc_write = (op == 6'h04) ? zero : ~zero;
      end
      S_JUMP:    begin
        pc_write = 1'b1;
        pc_src   = 2'd2;
        if (link) begin
          reg_write = 1'b1;
          reg_dst   = 2'd2;
          wb_src    = 2'd2;
        end
      end
      S_JR:      begin pc_write = 1'b1; pc_src = 2'd3; end
      default:   ;
    endcase
  end

  assign CEN = ~mem_state;
  assign WEN = ~(state == S_MWR);
  assign OEN = ~(state == S_MRD);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: two instances (MEM_WAIT=2 and MEM_WAIT=0) checked cycle by cycle against
// per-instruction state sequences and a per-state output table, with directed and random instruction mixes.
module tb_mips_mc_ctrl;

  logic       clk, rst_n, zero;
  logic [5:0] op, funct;

  logic [3:0] state_a, state_b;
  logic       pc_write_a, ir_write_a, reg_write_a, cen_a, wen_a, oen_a, illegal_a;
  logic [1:0] pc_src_a, reg_dst_a, wb_src_a, alu_src_b_a, alu_op_a;
  logic       pc_write_b, ir_write_b, reg_write_b, cen_b, wen_b, oen_b, illegal_b;
  logic [1:0] pc_src_b, reg_dst_b, wb_src_b, alu_src_b_b, alu_op_b;

  int  n_cmp = 0;
  int  n_fail = 0;
  logic ill_a = 1'b0;
  logic ill_b = 1'b0;

  mips_mc_ctrl #(.MEM_WAIT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .state(state_a),
    .pc_write(pc_write_a), .pc_src(pc_src_a), .ir_write(ir_write_a), .reg_write(reg_write_a),
    .reg_dst(reg_dst_a), .wb_src(wb_src_a), .alu_src_b(alu_src_b_a), .alu_op(alu_op_a),
    .CEN(cen_a), .WEN(wen_a), .OEN(oen_a), .illegal(illegal_a));

  mips_mc_ctrl #(.MEM_WAIT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .state(state_b),
    .pc_write(pc_write_b), .pc_src(pc_src_b), .ir_write(ir_write_b), .reg_write(reg_write_b),
    .reg_dst(reg_dst_b), .wb_src(wb_src_b), .alu_src_b(alu_src_b_b), .alu_op(alu_op_b),
    .CEN(cen_b), .WEN(wen_b), .OEN(oen_b), .illegal(illegal_b));

  logic [15:0] vec_a, vec_b;
  assign vec_a = {pc_write_a, pc_src_a, ir_write_a, reg_write_a, reg_dst_a, wb_src_a,
                  alu_src_b_a, alu_op_a, cen_a, wen_a, oen_a};
  assign vec_b = {pc_write_b, pc_src_b, ir_write_b, reg_write_b, reg_dst_b, wb_src_b,
                  alu_src_b_b, alu_op_b, cen_b, wen_b, oen_b};

  localparam logic [15:0] IDLE_VEC = 16'b0_00_0_0_00_00_00_00_111;

  always #5 clk = ~clk;

  // Instruction class: 0 illegal, 1 R-type, 2 shift, 3 jr, 4 addi, 5 lw, 6 sw, 7 branch, 8 jump
  function automatic int cls(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) begin
      if (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A) return 1;
      if (f == 6'h00 || f == 6'h02) return 2;
      if (f == 6'h08) return 3;
      return 0;
    end
    if (o == 6'h08) return 4;
    if (o == 6'h23) return 5;
    if (o == 6'h2B) return 6;
    if (o == 6'h04 || o == 6'h05) return 7;
    if (o == 6'h02 || o == 6'h03) return 8;
    return 0;
  endfunction

  function automatic void build_seq(input logic [5:0] o, input logic [5:0] f, input int w,
                                    output int len, output logic [3:0] s [0:23]);
    int c;
    c = cls(o, f);
    for (int i = 0; i < 24; i++) s[i] = 4'd1;
    s[0] = 4'd1;
    s[1] = 4'd2;
    len = 2;
    case (c)
      1: begin s[2] = 4'd3; s[3] = 4'd5; len = 4; end
      2: begin s[2] = 4'd4; s[3] = 4'd5; len = 4; end
      3: begin s[2] = 4'd14; len = 3; end
      4: begin s[2] = 4'd6; s[3] = 4'd7; len = 4; end
      5: begin
        s[2] = 4'd8;
        for (int k = 0; k <= w; k++) s[3 + k] = 4'd9;
        s[4 + w] = 4'd10;
        len = 5 + w;
      end
      6: begin
        s[2] = 4'd8;
        for (int k = 0; k <= w; k++) s[3 + k] = 4'd11;
        len = 4 + w;
      end
      7: begin s[2] = 4'd12; len = 3; end
      8: begin s[2] = 4'd13; len = 3; end
      default: len = 2;
    endcase
  endfunction

  // Expected outputs for a state: {pc_write, pc_src, ir_write, reg_write, reg_dst, wb_src, alu_src_b, alu_op, CEN, WEN, OEN}
  function automatic logic [15:0] exp_out(input logic [3:0] s, input logic [5:0] o, input logic z);
    logic pcw, irw, rw;
    logic [1:0] pcs, rd, wb, asb, aop;
    logic [2:0] strb;
    pcw = 0; irw = 0; rw = 0; pcs = 0; rd = 0; wb = 0; asb = 0; aop = 0; strb = 3'b111;
    case (s)
      4'd1:  begin irw = 1; pcw = 1; end
      4'd2:  asb = 3;
      4'd3:  aop = 2;
      4'd4:  begin asb = 2; aop = 2; end
      4'd5:  begin rw = 1; rd = 1; end
      4'd6:  asb = 1;
      4'd7:  rw = 1;
      4'd8:  asb = 1;
      4'd9:  strb = 3'b010;
      4'd10: begin rw = 1; wb = 1; end
      4'd11: strb = 3'b001;
      4'd12: begin aop = 1; pcs = 1; pcw = (o == 6'h04) ? z : ~z; end
      4'd13: begin pcw = 1; pcs = 2; if (o == 6'h03) begin rw = 1; rd = 2; wb = 2; end end
      4'd14: begin pcw = 1; pcs = 3; end
      default: ;
    endcase
    return {pcw, pcs, irw, rw, rd, wb, asb, aop, strb};
  endfunction

  // Runs one instruction starting in fetch on instance sel (0: MEM_WAIT=2, 1: MEM_WAIT=0)
  task automatic do_instr(input int sel, input logic [5:0] o, input logic [5:0] f, input logic z,
                          input string tag);
    int len;
    logic [3:0] seq [0:23];
    logic [3:0] obs_st;
    logic [15:0] obs_v, ev;
    logic obs_il, eil;
    op = o; funct = f; zero = z;
    build_seq(o, f, (sel == 0) ? 2 : 0, len, seq);
    for (int i = 0; i < len; i++) begin
      obs_st = (sel == 0) ? state_a : state_b;
      obs_v  = (sel == 0) ? vec_a : vec_b;
      obs_il = (sel == 0) ? illegal_a : illegal_b;
      eil    = (sel == 0) ? ill_a : ill_b;
      ev     = exp_out(seq[i], o, z);
      n_cmp++;
      if (obs_st !== seq[i] || obs_v !== ev || obs_il !== eil) begin
        n_fail++;
        $display("FAIL %s cyc%0d: got state=%0d out=%h illegal=%b, want state=%0d out=%h illegal=%b",
                 tag, i, obs_st, obs_v, obs_il, seq[i], ev, eil);
      end
      @(posedge clk); #1;
    end
    if (cls(o, f) == 0) begin
      if (sel == 0) ill_a = 1'b1; else ill_b = 1'b1;
    end
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (state_a !== 4'd1 || state_b !== 4'd1) begin
      n_fail++;
      $display("FAIL %s: got states %0d/%0d, want 1/1", tag, state_a, state_b);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (state_a !== 4'd0 || vec_a !== IDLE_VEC || illegal_a !== 1'b0 ||
        state_b !== 4'd0 || vec_b !== IDLE_VEC || illegal_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got a=%0d/%h/%b b=%0d/%h/%b, want 0/%h/0",
               state_a, vec_a, illegal_a, state_b, vec_b, illegal_b, IDLE_VEC);
    end
    release_reset("reset_release");
  endtask

  task automatic test_alu();
    do_instr(0, 6'h00, 6'h20, 1'b0, "add");
    do_instr(0, 6'h00, 6'h2A, 1'b1, "slt");
    do_instr(0, 6'h00, 6'h02, 1'b0, "srl");
    do_instr(0, 6'h08, 6'($urandom), 1'($urandom), "addi");
  endtask

  task automatic test_lw();
    do_instr(0, 6'h23, 6'($urandom), 1'b0, "lw_wait2");
    do_instr(0, 6'h2B, 6'($urandom), 1'b0, "sw_wait2");
  endtask

  task automatic test_branch_jump();
    do_instr(0, 6'h04, 6'h00, 1'b1, "beq_taken");
    do_instr(0, 6'h04, 6'h00, 1'b0, "beq_not");
    do_instr(0, 6'h05, 6'h00, 1'b1, "bne_not");
    do_instr(0, 6'h05, 6'h00, 1'b0, "bne_taken");
    do_instr(0, 6'h02, 6'h00, 1'b0, "j");
    do_instr(0, 6'h03, 6'h00, 1'b0, "jal");
    do_instr(0, 6'h00, 6'h08, 1'b0, "jr");
  endtask

  task automatic test_illegal();
    do_instr(0, 6'h3F, 6'h00, 1'b0, "op3f");
    do_instr(0, 6'h00, 6'h20, 1'b0, "add_after_illegal");
    do_instr(0, 6'h23, 6'h00, 1'b0, "lw_after_illegal");
  endtask

  task automatic test_random();
    logic [5:0] legal_op [0:12];
    logic [5:0] legal_fn [0:12];
    int k;
    legal_op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h03};
    legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, 12);
        do_instr(0, legal_op[k], legal_fn[k], 1'($urandom), "rand_legal");
      end else begin
        do_instr(0, 6'($urandom), 6'($urandom), 1'($urandom), "rand_any");
      end
    end
  endtask

  task automatic test_reset_mid_write();
    op = 6'h2B; funct = 6'h00; zero = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (state_a !== 4'd11 || cen_a !== 1'b0 || wen_a !== 1'b0) begin
      n_fail++;
      $display("FAIL mwr_entry: got state=%0d CEN=%b WEN=%b, want 11 0 0", state_a, cen_a, wen_a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (state_a !== 4'd0 || {cen_a, wen_a, oen_a} !== 3'b111 || state_b !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset: got state=%0d strobes=%b b_state=%0d, want 0 111 0",
               state_a, {cen_a, wen_a, oen_a}, state_b);
    end
    ill_a = 1'b0;
    ill_b = 1'b0;
    release_reset("mid_write_release");
    n_cmp++;
    if (illegal_a !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_cleared: got %b, want 0", illegal_a);
    end
  endtask

  task automatic test_sw_nowait();
    do_instr(1, 6'h2B, 6'h00, 1'b0, "sw_wait0");
    do_instr(1, 6'h23, 6'h00, 1'b0, "lw_wait0");
    do_instr(1, 6'h03, 6'h00, 1'b1, "jal_wait0");
    do_instr(1, 6'h2B, 6'h11, 1'b1, "sw_wait0_b");
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    op = 6'h00; funct = 6'h00; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_alu();
    test_lw();
    test_branch_jump();
    test_illegal();
    test_random();
    test_reset_mid_write();
    test_sw_nowait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
